// File: rtl/ulpi_reg_engine.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_reg_engine
// Purpose  : ULPI link-side register access engine. Accepts one register
//            read/write request at a time, runs the ULPI TXCMD / extended
//            address / data / STP sequence, handles PHY aborts with bounded
//            retry and guards every PHY handshake with a timeout.
// Ports    : clk, reset_n           - ULPI clock, async active-low reset
//            req_*                  - request handshake (valid/ready)
//            rsp_*                  - one-cycle response pulse + read data
//            ulpi_dir/nxt/data_in   - PHY-driven ULPI signals
//            ulpi_stp/data_out/oe   - link-driven ULPI signals (tri-state
//                                     buffer lives outside this block)
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_reg_engine #(
  parameter int EXT_ADDR_EN = 1,
  parameter int NXT_TIMEOUT = 255,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe
);

  localparam int               TMO_W     = $clog2(NXT_TIMEOUT + 1);
  localparam int               RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(NXT_TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic             EXT_OK    = (EXT_ADDR_EN != 0);
  localparam logic [5:0]       EXT_CODE  = 6'h2F;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT_BUS = 4'd1,
    TXCMD    = 4'd2,
    EXTADDR  = 4'd3,
    WDATA    = 4'd4,
    STOP     = 4'd5,
    RD_TURN  = 4'd6,
    RD_DATA  = 4'd7,
    RD_END   = 4'd8,
    RESP     = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic             req_ready_q;
  logic             write_q, write_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             reissue_q, reissue_d;   // read was aborted in RD_DATA
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             w_accept;
  logic             w_req_ext;
  logic             w_cur_ext;
  logic [TMO_W-1:0] w_tmo_inc;
  logic             w_tmo_hit;
  logic             w_abort;
  logic             w_abort_rd;
  logic             w_waiting;

  assign w_accept  = (state_q == IDLE) && req_valid && req_ready_q;
  assign w_req_ext = (req_addr[7:6] != 2'b00) || (req_addr == 8'h2F);
  assign w_cur_ext = (addr_q[7:6] != 2'b00) || (addr_q == 8'h2F);
  assign w_tmo_inc = tmo_q + 1'b1;
  assign w_tmo_hit = (w_tmo_inc == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      reissue_q   <= 1'b0;
      retry_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      reissue_q   <= reissue_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    reissue_d  = reissue_q;
    retry_d    = retry_q;
    w_abort    = 1'b0;
    w_abort_rd = 1'b0;
    w_waiting  = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          err_d     = 1'b0;
          reissue_d = 1'b0;
          retry_d   = '0;
          if (w_req_ext && !EXT_OK) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ulpi_dir ? WAIT_BUS : TXCMD;
          end
        end
      end
      WAIT_BUS: if (!ulpi_dir) state_d = TXCMD;
      TXCMD: begin
        if (ulpi_dir)      w_abort = 1'b1;
        else if (ulpi_nxt) state_d = w_cur_ext ? EXTADDR : (write_q ? WDATA : RD_TURN);
        else               w_waiting = 1'b1;
      end
      EXTADDR: begin
        if (ulpi_dir)      w_abort = 1'b1;
        else if (ulpi_nxt) state_d = write_q ? WDATA : RD_TURN;
        else               w_waiting = 1'b1;
      end
      WDATA: begin
        if (ulpi_dir)      w_abort = 1'b1;
        else if (ulpi_nxt) state_d = STOP;
        else               w_waiting = 1'b1;
      end
      STOP:    state_d = RESP;
      RD_TURN: begin
        if (ulpi_dir) state_d = RD_DATA;
        else          w_waiting = 1'b1;
      end
      RD_DATA: begin
        if (ulpi_nxt && ulpi_dir) begin
          w_abort    = 1'b1;
          w_abort_rd = 1'b1;
        end else begin
          rdata_d = ulpi_data_in;
          state_d = RD_END;
        end
      end
      RD_END: begin
        if (!ulpi_dir) begin
          state_d   = reissue_q ? TXCMD : RESP;
          reissue_d = 1'b0;
        end else begin
          w_waiting = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Aborts beyond the retry budget terminate the request with an error.
    if (w_abort) begin
      if (retry_q >= RTY_LIMIT) begin
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        retry_d   = retry_q + 1'b1;
        state_d   = w_abort_rd ? RD_END : WAIT_BUS;
        reissue_d = w_abort_rd;
      end
    end

    if (w_waiting && w_tmo_hit) begin
      err_d   = 1'b1;
      state_d = RESP;
    end
  end

  // Counter only advances while parked in a waiting state; any transition clears it.
  assign tmo_d = (w_waiting && !w_tmo_hit) ? w_tmo_inc : '0;

  always_comb begin
    ulpi_data_out = 8'h00;
    case (state_q)
      TXCMD:   ulpi_data_out = {(write_q ? 2'b10 : 2'b11), (w_cur_ext ? EXT_CODE : addr_q[5:0])};
      EXTADDR: ulpi_data_out = addr_q;
      WDATA:   ulpi_data_out = wdata_q;
      default: ulpi_data_out = 8'h00;
    endcase
  end

  // Bus released combinationally the moment the PHY raises dir.
  assign ulpi_data_oe = ((state_q == TXCMD) || (state_q == EXTADDR) ||
                         (state_q == WDATA) || (state_q == STOP)) && !ulpi_dir;
  assign ulpi_stp     = (state_q == STOP);
  assign req_ready    = req_ready_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_error    = (state_q == RESP) && err_q;
  assign rsp_rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_reg_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_reg_engine
// Purpose  : Directed self-checking bench for ulpi_reg_engine. Drives the
//            request port and a scripted PHY on the falling edge and checks
//            outputs on the falling edge. A second instance with extended
//            addressing disabled shares the PHY inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_reg_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, rsp_error;
  logic [7:0] rsp_rdata;
  logic       ulpi_dir, ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic       ulpi_stp, ulpi_data_oe;
  logic [7:0] ulpi_data_out;

  logic       req_valid_b;
  logic       req_ready_b, rsp_valid_b, rsp_error_b, ulpi_stp_b, ulpi_data_oe_b;
  logic [7:0] rsp_rdata_b, ulpi_data_out_b;
  logic       oe_b_seen = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ulpi_reg_engine u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_stp(ulpi_stp), .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe)
  );

  ulpi_reg_engine #(.EXT_ADDR_EN(0)) u_dut_noext (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_stp(ulpi_stp_b), .ulpi_data_out(ulpi_data_out_b), .ulpi_data_oe(ulpi_data_oe_b)
  );

  always @(posedge clk) if (ulpi_data_oe_b === 1'b1) oe_b_seen = 1'b1;

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns on the falling edge
  // after the accepting rising edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got valid=%b err=%b expected 0/0", rsp_valid, rsp_error); end
    n_tests++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h expected 00", rsp_rdata); end
    n_tests++; if (ulpi_stp !== 1'b0 || ulpi_data_out !== 8'h00 || ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ulpi: got stp=%b data=%h oe=%b expected 0/00/0", ulpi_stp, ulpi_data_out, ulpi_data_oe); end
    reset_n = 1'b1;
    tick();
    n_tests++; if (req_ready !== 1'b1 || req_ready_b !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: got %b/%b expected 1/1", req_ready, req_ready_b); end
  endtask

  task automatic test_imm_read();
    issue(1'b0, 8'h00, 8'h00);
    n_tests++; if (ulpi_data_out !== 8'hC0 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL rd_txcmd: got data=%h oe=%b expected c0/1", ulpi_data_out, ulpi_data_oe); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_busy: got %b expected 0", req_ready); end
    ulpi_nxt = 1'b1; tick();
    n_tests++; if (ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_drop: got %b expected 0", ulpi_data_oe); end
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_data_in = 8'h0F; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rsp: got %b expected 0", rsp_valid); end
    tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h0F || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got valid=%b data=%h err=%b expected 1/0f/0", rsp_valid, rsp_rdata, rsp_error); end
    tick();
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_pulse_end: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_imm_write();
    issue(1'b1, 8'h0A, 8'h55);
    n_tests++; if (ulpi_data_out !== 8'h8A || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL wr_txcmd: got data=%h oe=%b expected 8a/1", ulpi_data_out, ulpi_data_oe); end
    ulpi_nxt = 1'b1; tick();
    n_tests++; if (ulpi_data_out !== 8'h55) begin n_fail++; $display("FAIL wr_wdata: got %h expected 55", ulpi_data_out); end
    tick();
    ulpi_nxt = 1'b0;
    n_tests++; if (ulpi_stp !== 1'b1 || ulpi_data_out !== 8'h00 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL wr_stop: got stp=%b data=%h oe=%b expected 1/00/1", ulpi_stp, ulpi_data_out, ulpi_data_oe); end
    tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || ulpi_stp !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got valid=%b err=%b stp=%b expected 1/0/0", rsp_valid, rsp_error, ulpi_stp); end
    tick();
  endtask

  task automatic test_ext_read();
    issue(1'b0, 8'h80, 8'h00);
    n_tests++; if (ulpi_data_out !== 8'hEF) begin n_fail++; $display("FAIL ext_txcmd: got %h expected ef", ulpi_data_out); end
    ulpi_nxt = 1'b1; tick();
    n_tests++; if (ulpi_data_out !== 8'h80 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL ext_addr: got data=%h oe=%b expected 80/1", ulpi_data_out, ulpi_data_oe); end
    tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_data_in = 8'hA5; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL ext_rsp: got valid=%b data=%h err=%b expected 1/a5/0", rsp_valid, rsp_rdata, rsp_error); end
    tick();
    // Same request against the instance with extended addressing disabled.
    req_write = 1'b0; req_addr = 8'h80; req_valid_b = 1'b1;
    tick();
    req_valid_b = 1'b0;
    n_tests++; if (rsp_valid_b !== 1'b1 || rsp_error_b !== 1'b1) begin n_fail++; $display("FAIL noext_rsp: got valid=%b err=%b expected 1/1", rsp_valid_b, rsp_error_b); end
    n_tests++; if (ulpi_stp_b !== 1'b0 || ulpi_data_out_b !== 8'h00 || rsp_rdata_b !== 8'h00) begin n_fail++; $display("FAIL noext_bus: got stp=%b data=%h rdata=%h expected 0/00/00", ulpi_stp_b, ulpi_data_out_b, rsp_rdata_b); end
    tick();
    n_tests++; if (oe_b_seen !== 1'b0 || rsp_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin n_fail++; $display("FAIL noext_idle: got oe_seen=%b valid=%b ready=%b expected 0/0/1", oe_b_seen, rsp_valid_b, req_ready_b); end
  endtask

  task automatic test_abort_retry();
    issue(1'b0, 8'h01, 8'h00);
    n_tests++; if (ulpi_data_out !== 8'hC1 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL ab_txcmd: got data=%h oe=%b expected c1/1", ulpi_data_out, ulpi_data_oe); end
    ulpi_dir = 1'b1; #1;
    n_tests++; if (ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL ab_oe_same_cycle: got %b expected 0", ulpi_data_oe); end
    tick(); tick();
    ulpi_dir = 1'b0; tick();
    n_tests++; if (ulpi_data_out !== 8'hC1 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL ab_reissue: got data=%h oe=%b expected c1/1", ulpi_data_out, ulpi_data_oe); end
    ulpi_nxt = 1'b1; tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_data_in = 8'hF0; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hF0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL ab_rsp: got valid=%b data=%h err=%b expected 1/f0/0", rsp_valid, rsp_rdata, rsp_error); end
    tick();
    // Four consecutive aborts exhaust a budget of three retries.
    issue(1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ulpi_dir = 1'b1; tick();
      if (i < 3) begin
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ab4_early_rsp%0d: got %b expected 0", i, rsp_valid); end
        ulpi_dir = 1'b0; tick();
        n_tests++; if (ulpi_data_out !== 8'hC2) begin n_fail++; $display("FAIL ab4_txcmd%0d: got %h expected c2", i, ulpi_data_out); end
      end
    end
    n_tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin n_fail++; $display("FAIL ab4_err: got valid=%b err=%b expected 1/1", rsp_valid, rsp_error); end
    ulpi_dir = 1'b0; tick();
  endtask

  task automatic test_rd_data_abort();
    issue(1'b0, 8'h03, 8'h00);
    ulpi_nxt = 1'b1; tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_nxt = 1'b1; ulpi_data_in = 8'hEE; tick();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rda_no_rsp: got %b expected 0", rsp_valid); end
    ulpi_nxt = 1'b0; ulpi_dir = 1'b0; ulpi_data_in = 8'h00; tick();
    n_tests++; if (ulpi_data_out !== 8'hC3 || ulpi_data_oe !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rda_reissue: got data=%h oe=%b valid=%b expected c3/1/0", ulpi_data_out, ulpi_data_oe, rsp_valid); end
    ulpi_nxt = 1'b1; tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_data_in = 8'h3C; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rda_rsp: got valid=%b data=%h err=%b expected 1/3c/0", rsp_valid, rsp_rdata, rsp_error); end
    tick();
  endtask

  task automatic test_timeout();
    int  cnt;
    bit  found;
    cnt = 0; found = 1'b0;
    issue(1'b1, 8'h04, 8'h11);
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid === 1'b1) begin found = 1'b1; break; end
      if (ulpi_data_out === 8'h84 && ulpi_data_oe === 1'b1) cnt++;
      tick();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL tmo_rsp: got no response in 400 cycles expected one"); end
    n_tests++; if (cnt != 255) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 255", cnt); end
    n_tests++; if (rsp_error !== 1'b1 || ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b oe=%b expected 1/0", rsp_error, ulpi_data_oe); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 8'h05, 8'h00);
    ulpi_nxt = 1'b1; tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    reset_n = 1'b0; #1;
    n_tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_rsp: got ready=%b valid=%b err=%b rdata=%h expected 0/0/0/00", req_ready, rsp_valid, rsp_error, rsp_rdata); end
    n_tests++; if (ulpi_stp !== 1'b0 || ulpi_data_out !== 8'h00 || ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_ulpi: got stp=%b data=%h oe=%b expected 0/00/0", ulpi_stp, ulpi_data_out, ulpi_data_oe); end
    ulpi_dir = 1'b0; tick();
    reset_n = 1'b1; tick();
    n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_recover: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    issue(1'b0, 8'h06, 8'h00);
    n_tests++; if (ulpi_data_out !== 8'hC6) begin n_fail++; $display("FAIL midrst_txcmd: got %h expected c6", ulpi_data_out); end
    ulpi_nxt = 1'b1; tick();
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1; tick();
    ulpi_data_in = 8'h66; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00; tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h66 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp2: got valid=%b data=%h err=%b expected 1/66/0", rsp_valid, rsp_rdata, rsp_error); end
    tick();
  endtask

  task automatic test_dir_idle();
    ulpi_dir = 1'b1;
    issue(1'b1, 8'h07, 8'h22);
    n_tests++; if (req_ready !== 1'b0 || ulpi_data_oe !== 1'b0 || ulpi_data_out !== 8'h00) begin n_fail++; $display("FAIL diridle_wait: got ready=%b oe=%b data=%h expected 0/0/00", req_ready, ulpi_data_oe, ulpi_data_out); end
    // A second request held high mid-transaction must not disturb it.
    req_write = 1'b0; req_addr = 8'h09; req_valid = 1'b1;
    ulpi_dir = 1'b0; tick();
    n_tests++; if (ulpi_data_out !== 8'h87 || ulpi_data_oe !== 1'b1) begin n_fail++; $display("FAIL diridle_txcmd: got data=%h oe=%b expected 87/1", ulpi_data_out, ulpi_data_oe); end
    ulpi_nxt = 1'b1; tick();
    n_tests++; if (ulpi_data_out !== 8'h22) begin n_fail++; $display("FAIL diridle_wdata: got %h expected 22", ulpi_data_out); end
    tick();
    ulpi_nxt = 1'b0; tick();
    req_valid = 1'b0;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL diridle_rsp: got valid=%b err=%b expected 1/0", rsp_valid, rsp_error); end
    tick();
    n_tests++; if (req_ready !== 1'b1 || ulpi_data_oe !== 1'b0) begin n_fail++; $display("FAIL diridle_idle: got ready=%b oe=%b expected 1/0", req_ready, ulpi_data_oe); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    test_reset();
    test_imm_read();
    test_imm_write();
    test_ext_read();
    test_abort_retry();
    test_rd_data_abort();
    test_timeout();
    test_reset_mid();
    test_dir_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
